// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped branch target buffer with per-entry
// saturating counters. Fetch lookup is combinational on PCF. The EX stage
// trains the tables with resolved outcomes, gets a mispredict/redirect
// request back, and the block keeps running branch and miss statistics.

module branch_predictor_btb #(
   parameter int INDEX_BITS = 6,
   parameter int TAG_BITS   = 8,
   parameter int CNT_WIDTH  = 2,
   parameter int STAT_WIDTH = 32
) (
   input  logic                  CPU_CLK,
   input  logic                  CPU_RST,
   input  logic [31:0]           PCF,
   output logic                  PredTakenF,
   output logic [31:0]           PredTargetF,
   input  logic                  UpdateE,
   input  logic [31:0]           PCE,
   input  logic                  BranchE,
   input  logic [31:0]           BranchTargetE,
   input  logic                  PredTakenE,
   input  logic [31:0]           PredTargetE,
   output logic                  MispredictE,
   output logic [31:0]           RedirectPCE,
   output logic [STAT_WIDTH-1:0] BranchCnt,
   output logic [STAT_WIDTH-1:0] MissCnt
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int TAG_LSB = INDEX_BITS + 2;
   localparam int TAG_MSB = INDEX_BITS + TAG_BITS + 1;

   // Counter landmarks: saturation ceiling, weakly-taken (allocation value)
   // and weakly-not-taken (reset value). The MSB of the counter is the
   // taken/not-taken decision.
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T  = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
   localparam logic [CNT_WIDTH-1:0] CNT_WEAK_NT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

   logic [ENTRIES-1:0]   valid_q;
   logic [TAG_BITS-1:0]  tag_q    [ENTRIES];
   logic [31:0]          target_q [ENTRIES];
   logic [CNT_WIDTH-1:0] cnt_q    [ENTRIES];

   logic [INDEX_BITS-1:0] idx_f;
   logic [INDEX_BITS-1:0] idx_e;
   logic [TAG_BITS-1:0]   tag_f;
   logic [TAG_BITS-1:0]   tag_e;
   logic                  hit_f;
   logic                  hit_e;

   assign idx_f = PCF[INDEX_BITS+1:2];
   assign tag_f = PCF[TAG_MSB:TAG_LSB];
   assign idx_e = PCE[INDEX_BITS+1:2];
   assign tag_e = PCE[TAG_MSB:TAG_LSB];

   // Fetch lookup: reads the tables as they stand, so an update on the same
   // index this cycle is only seen from the next cycle on.
   always_comb begin
      hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
      PredTakenF  = hit_f && cnt_q[idx_f][CNT_WIDTH-1];
      PredTargetF = PredTakenF ? target_q[idx_f] : PCF + 32'd4;
   end

   // EX-side hit detection and mispredict/redirect decision.
   always_comb begin
      hit_e       = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
      MispredictE = UpdateE && ((BranchE != PredTakenE) ||
                                (BranchE && (PredTargetE != BranchTargetE)));
      RedirectPCE = BranchE ? BranchTargetE : PCE + 32'd4;
   end

   // Valid bits and counters: hits train the counter, taken misses allocate.
   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_q[i] <= CNT_WEAK_NT;
         end
      end else if (UpdateE) begin
         if (hit_e) begin
            if (BranchE) begin
               if (cnt_q[idx_e] != CNT_MAX) cnt_q[idx_e] <= cnt_q[idx_e] + CNT_WIDTH'(1);
            end else begin
               if (cnt_q[idx_e] != '0) cnt_q[idx_e] <= cnt_q[idx_e] - CNT_WIDTH'(1);
            end
         end else if (BranchE) begin
            valid_q[idx_e] <= 1'b1;
            cnt_q[idx_e]   <= CNT_WEAK_T;
         end
      end
   end

   // Tag and target storage needs no reset: an entry is only trusted once its
   // valid bit is set, so a write that lands during reset is harmless.
   always_ff @(posedge CPU_CLK) begin
      if (UpdateE && BranchE) begin
         target_q[idx_e] <= BranchTargetE;
         if (!hit_e) tag_q[idx_e] <= tag_e;
      end
   end

   // Statistics counters, free-running and wrapping.
   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         BranchCnt <= '0;
         MissCnt   <= '0;
      end else begin
         if (UpdateE)     BranchCnt <= BranchCnt + STAT_WIDTH'(1);
         if (MispredictE) MissCnt   <= MissCnt + STAT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Testbench for branch_predictor_btb: directed scenarios with literal
// expectations followed by randomized traffic, all checked against a
// behavioural table model kept in the bench.

module tb_branch_predictor_btb;

   localparam int ENTRIES = 64;

   logic        CPU_CLK = 1'b0;
   logic        CPU_RST = 1'b0;
   logic [31:0] PCF = '0;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        UpdateE = 1'b0;
   logic [31:0] PCE = '0;
   logic        BranchE = 1'b0;
   logic [31:0] BranchTargetE = '0;
   logic        PredTakenE = 1'b0;
   logic [31:0] PredTargetE = '0;
   logic        MispredictE;
   logic [31:0] RedirectPCE;
   logic [31:0] BranchCnt;
   logic [31:0] MissCnt;

   branch_predictor_btb dut (
      .CPU_CLK      (CPU_CLK),
      .CPU_RST      (CPU_RST),
      .PCF          (PCF),
      .PredTakenF   (PredTakenF),
      .PredTargetF  (PredTargetF),
      .UpdateE      (UpdateE),
      .PCE          (PCE),
      .BranchE      (BranchE),
      .BranchTargetE(BranchTargetE),
      .PredTakenE   (PredTakenE),
      .PredTargetE  (PredTargetE),
      .MispredictE  (MispredictE),
      .RedirectPCE  (RedirectPCE),
      .BranchCnt    (BranchCnt),
      .MissCnt      (MissCnt)
   );

   // 10-unit clock period.
   always #5 CPU_CLK = ~CPU_CLK;

   int checks   = 0;
   int failures = 0;
   bit compare_en = 1'b0;

   // Behavioural model: one record per table slot, plain integers.
   bit          m_valid  [ENTRIES];
   int unsigned m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_cnt    [ENTRIES];
   logic [31:0] m_branch;
   logic [31:0] m_miss;

   function automatic int unsigned idxOf(input logic [31:0] pc);
      return (pc / 4) % ENTRIES;
   endfunction

   function automatic int unsigned tagOf(input logic [31:0] pc);
      return (pc / 256) % 256;
   endfunction

   function automatic bit modelTaken(input logic [31:0] pc);
      int unsigned i;
      i = idxOf(pc);
      return m_valid[i] && (m_tag[i] == tagOf(pc)) && (m_cnt[i] >= 2);
   endfunction

   function automatic logic [31:0] modelTarget(input logic [31:0] pc);
      if (modelTaken(pc)) return m_target[idxOf(pc)];
      return pc + 32'd4;
   endfunction

   function automatic bit modelMiss();
      if (!UpdateE) return 1'b0;
      if (BranchE != PredTakenE) return 1'b1;
      return BranchE && (PredTargetE != BranchTargetE);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic upd, input logic [31:0] pce,
                                input logic br, input logic [31:0] bt,
                                input logic pte, input logic [31:0] ptgt,
                                input logic [31:0] pcf);
      UpdateE       = upd;
      PCE           = pce;
      BranchE       = br;
      BranchTargetE = bt;
      PredTakenE    = pte;
      PredTargetE   = ptgt;
      PCF           = pcf;
   endtask

   task automatic step();
      @(posedge CPU_CLK);
      #1;
   endtask

   // Model state advances on each edge; reset clears it immediately.
   always @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
         end
         m_branch = '0;
         m_miss   = '0;
      end else if (UpdateE) begin
         automatic int unsigned i = idxOf(PCE);
         automatic bit hit = m_valid[i] && (m_tag[i] == tagOf(PCE));
         if (modelMiss()) m_miss = m_miss + 32'd1;
         m_branch = m_branch + 32'd1;
         if (hit) begin
            if (BranchE) begin
               if (m_cnt[i] < 3) m_cnt[i] = m_cnt[i] + 1;
               m_target[i] = BranchTargetE;
            end else if (m_cnt[i] > 0) begin
               m_cnt[i] = m_cnt[i] - 1;
            end
         end else if (BranchE) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = tagOf(PCE);
            m_target[i] = BranchTargetE;
            m_cnt[i]    = 2;
         end
      end
   end

   // Compare all outputs against the model every cycle, mid-period.
   always @(negedge CPU_CLK) begin
      if (compare_en) begin
         checkOutput("m_PredTakenF", {31'd0, PredTakenF}, {31'd0, modelTaken(PCF)});
         checkOutput("m_PredTargetF", PredTargetF, modelTarget(PCF));
         checkOutput("m_MispredictE", {31'd0, MispredictE}, {31'd0, modelMiss()});
         if (modelMiss())
            checkOutput("m_RedirectPCE", RedirectPCE, BranchE ? BranchTargetE : PCE + 32'd4);
         checkOutput("m_BranchCnt", BranchCnt, m_branch);
         checkOutput("m_MissCnt", MissCnt, m_miss);
      end
   end

   function automatic logic [31:0] randPc();
      logic [31:0] pc;
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) pc = pc | 32'hFFFF_FF00;
      return pc;
   endfunction

   function automatic logic [31:0] randTarget();
      return 32'h0000_1000 + ($urandom_range(0, 3) << 4);
   endfunction

   // Directed scenarios followed by randomized traffic.
   initial begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      #2 CPU_RST = 1'b1;
      step();
      step();
      CPU_RST    = 1'b0;
      compare_en = 1'b1;

      // Post-reset lookup
      @(negedge CPU_CLK);
      checkOutput("rst_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      checkOutput("rst_PredTargetF", PredTargetF, 32'h104);
      checkOutput("rst_BranchCnt", BranchCnt, 32'd0);
      checkOutput("rst_MissCnt", MissCnt, 32'd0);

      // Cold taken branch, also the same-cycle hazard
      step();
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("cold_MispredictE", {31'd0, MispredictE}, 32'd1);
      checkOutput("cold_RedirectPCE", RedirectPCE, 32'h80);
      checkOutput("hazard_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("cold_PredTakenF", {31'd0, PredTakenF}, 32'd1);
      checkOutput("cold_PredTargetF", PredTargetF, 32'h80);
      checkOutput("cold_BranchCnt", BranchCnt, 32'd1);
      checkOutput("cold_MissCnt", MissCnt, 32'd1);

      // Hysteresis: two taken (cnt 3), then two not-taken
      for (int k = 0; k < 2; k++) begin
         step();
         applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 32'h100);
         @(negedge CPU_CLK);
         checkOutput("hyst_taken_MispredictE", {31'd0, MispredictE}, 32'd0);
      end
      step();
      applyStimulus(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("hyst_nt1_MispredictE", {31'd0, MispredictE}, 32'd1);
      checkOutput("hyst_nt1_RedirectPCE", RedirectPCE, 32'h104);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("hyst_cnt2_PredTakenF", {31'd0, PredTakenF}, 32'd1);
      step();
      applyStimulus(1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("hyst_nt2_MispredictE", {31'd0, MispredictE}, 32'd1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("hyst_cnt1_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      checkOutput("hyst_BranchCnt", BranchCnt, 32'd5);
      checkOutput("hyst_MissCnt", MissCnt, 32'd3);

      // Aliasing at index 0: 0x200 replaces the 0x100 entry
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h200);
      @(negedge CPU_CLK);
      checkOutput("alias_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      checkOutput("alias_PredTargetF", PredTargetF, 32'h204);
      step();
      applyStimulus(1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204, 32'h200);
      @(negedge CPU_CLK);
      checkOutput("alias_MispredictE", {31'd0, MispredictE}, 32'd1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("alias_old_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h200);
      @(negedge CPU_CLK);
      checkOutput("alias_new_PredTakenF", {31'd0, PredTakenF}, 32'd1);
      checkOutput("alias_new_PredTargetF", PredTargetF, 32'h300);
      checkOutput("alias_MissCnt", MissCnt, 32'd4);

      // Retrain 0x100 to bring MissCnt to 5, then pulse async reset
      step();
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("pre_rst_PredTakenF", {31'd0, PredTakenF}, 32'd1);
      checkOutput("pre_rst_MissCnt", MissCnt, 32'd5);
      #2 CPU_RST = 1'b1;
      #1;
      checkOutput("async_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      checkOutput("async_MissCnt", MissCnt, 32'd0);
      checkOutput("async_BranchCnt", BranchCnt, 32'd0);
      applyStimulus(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 32'h100);
      step();
      CPU_RST = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
      @(negedge CPU_CLK);
      checkOutput("rst_upd_PredTakenF", {31'd0, PredTakenF}, 32'd0);
      checkOutput("rst_upd_BranchCnt", BranchCnt, 32'd0);

      // Randomized traffic on a small PC space to force hits and aliasing
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] pce;
         logic [31:0] pcf;
         logic        pte;
         logic [31:0] ptgt;
         step();
         if (n % 700 == 350) CPU_RST = 1'b1;
         else CPU_RST = 1'b0;
         pce = randPc();
         pcf = ($urandom_range(0, 3) == 0) ? pce : randPc();
         if ($urandom_range(0, 3) != 0) begin
            pte  = modelTaken(pce);
            ptgt = modelTarget(pce);
         end else begin
            pte  = 1'($urandom_range(0, 1));
            ptgt = randTarget();
         end
         applyStimulus(($urandom_range(0, 9) < 7), pce, 1'($urandom_range(0, 1)),
                       randTarget(), pte, ptgt, pcf);
      end
      step();
      CPU_RST = 1'b0;
      @(negedge CPU_CLK);
      compare_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised dynamic branch predictor: the next generation of the EX-stage branch decision path. It combines a direct-mapped branch target buffer (BTB) with per-entry saturating counters, so fetch can redirect speculatively. IF-stage lookup is combinational on PCF. The EX stage trains the tables with the resolved outcome and receives a mispredict flag and a corrected PC. Two counters record branch and misprediction statistics.

## Interface
- INDEX_BITS, 6: log2 of entry count; default 64 entries.
- TAG_BITS, 8: tag width stored per entry.
- CNT_WIDTH, 2: saturating counter width (≥1).
- STAT_WIDTH, 32: width of the statistics counters.
- CPU_CLK  in  1  single clock; all state changes on the rising edge.
- CPU_RST  in  1  asynchronous, active-high reset.
- PCF  in  32  fetch PC for lookup.
- PredTakenF  out  1  fetch-stage taken prediction.
- PredTargetF  out  32  next fetch PC.
- UpdateE  in  1  a conditional branch is resolving in EX this cycle, and EX is not stalled or flushed.
- PCE  in  32  PC of the resolving branch.
- BranchE  in  1  actual outcome: 1 = taken.
- BranchTargetE  in  32  actual taken target.
- PredTakenE, PredTargetE  in  1, 32  the prediction made for this branch, piped from F to E.
- MispredictE  out  1  redirect/flush request.
- RedirectPCE  out  32  correct next PC.
- BranchCnt, MissCnt  out  STAT_WIDTH each  statistics.

## Operation
- **Entry contents:** valid, tag[TAG_BITS], target[32], cnt[CNT_WIDTH].
- **Address split:** index = PC[INDEX_BITS+1:2]; tag = PC[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]. PC[1:0] is ignored.
- **Lookup:**
  - hitF = valid[idxF] && tag[idxF] == tagF.
  - PredTakenF = hitF && cnt[idxF] MSB.
  - PredTargetF = PredTakenF ? target[idxF] : PCF+4. The add wraps modulo 2^32.
- **Update, on UpdateE at the clock edge:**
  - Hit, taken: cnt saturating increment (max 2^CNT_WIDTH−1); target ← BranchTargetE.
  - Hit, not taken: cnt saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag=tagE, target=BranchTargetE, cnt=2^(CNT_WIDTH−1) (weakly taken). Any existing entry at that index is overwritten.
  - Miss, not taken: no change.
- **Mispredict (combinational):**
  - MispredictE = UpdateE && (BranchE != PredTakenE || (BranchE && PredTargetE != BranchTargetE)).
  - RedirectPCE = BranchE ? BranchTargetE : PCE+4. Valid only while MispredictE=1.
- **Statistics:**
  - BranchCnt increments on every UpdateE.
  - MissCnt increments when MispredictE=1.
  - Both wrap modulo 2^STAT_WIDTH with no saturation.
- **Reset:**
  - All valid=0; all cnt=2^(CNT_WIDTH−1)−1 (weakly not taken); BranchCnt=MissCnt=0.
  - Resulting outputs: PredTakenF=0, PredTargetF=PCF+4, MispredictE=0 when UpdateE=0.
  - Target and tag arrays need no reset.

## Timing
- Lookup and mispredict outputs: zero-cycle combinational paths.
- Training becomes visible on the cycle after the UpdateE edge.
- **Same-index read/write in the same cycle:** the lookup returns the pre-update contents. There is no write-through bypass.
- UpdateE=0 leaves all state frozen.
- BranchE, PredTakenE and the targets are don't-care when UpdateE=0.
- **Reset mid-operation:** state clears asynchronously on CPU_RST assertion, without waiting for a clock edge. An update arriving on the same edge that reset is asserted is discarded.
- Updates resume on the first rising edge after deassertion.

## Test plan
All scenarios use default parameters; counter values are shown as cnt.

1. **Post-reset lookup:** after reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104; BranchCnt=MissCnt=0.
2. **Cold taken branch:** UpdateE=1, PCE=0x100, BranchE=1, BranchTargetE=0x80, PredTakenE=0 -> MispredictE=1, RedirectPCE=0x80. After the edge: BranchCnt=1, MissCnt=1; PCF=0x100 gives PredTakenF=1, PredTargetF=0x80.
3. **Hysteresis:**
   - Two further taken updates at 0x100 (correctly predicted, MispredictE=0) -> cnt=3.
   - One not-taken update -> cnt=2; still predicts taken, MispredictE=1, RedirectPCE=0x104.
   - Second not-taken update -> cnt=1; PredTakenF=0 at 0x100.
4. **Aliasing:**
   - Entry at 0x100 valid; PCF=0x200 (same index 0, tag 0x02 ≠ 0x01) -> PredTakenF=0.
   - Taken update at 0x200, target 0x300 -> entry replaced with cnt=2; now PCF=0x100 misses and PCF=0x200 predicts 0x300.
5. **Same-cycle hazard:** PCF=0x100 with a first-time taken update at PCE=0x100 in the same cycle -> PredTakenF=0 that cycle, PredTakenF=1 the next cycle.
6. **Async reset:**
   - With trained entries and MissCnt=5, pulse CPU_RST between clock edges -> PredTakenF drops immediately and MissCnt=0.
   - A taken update on the following edge with CPU_RST still high is ignored.
